// File: rtl/dbg_slave_pkg.sv
// dbg_slave_pkg: shared defaults, command record and parity helper for the debug slave queue
package dbg_slave_pkg;
  localparam int DATA_W_DEF = 38;
  localparam int IR_W_DEF = 2;
  localparam int SYNC_STAGES_DEF = 3;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [DATA_W_DEF-1:0] data;
  } cmd_t;
  function automatic logic odd_parity_ok(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/dbg_sync_edge.sv
// dbg_sync_edge: multi-flop synchroniser followed by a registered rising-edge detector
module dbg_sync_edge #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] s, v;
  logic prev;
  // v tracks which chain stages hold real samples; prev starts high so a level already high at release never counts
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s <= '0;
      v <= '0;
      prev <= 1'b1;
      rise <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      v <= {v[STAGES-2:0], 1'b1};
      prev <= v[STAGES-1] ? s[STAGES-1] : 1'b1;
      rise <= v[STAGES-1] & s[STAGES-1] & ~prev;
    end
endmodule

// File: rtl/dbg_slave_cmd_queue.sv
// dbg_slave_cmd_queue: TCK-to-clk debug command capture into a first-word-fall-through queue
// Optional odd-parity check on sr[DATA_W-1] enabled by DBG_SLAVE_PARITY_EN.
module dbg_slave_cmd_queue
  import dbg_slave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IR_W = IR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int NUM_CH = 2**IR_W,
  localparam int LW = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] cmd_data,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [NUM_CH-1:0] cmd_ch,
  output logic              ir_update,
  output logic [LW-1:0]     level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        perr_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic uir_rise, udr_rise, par_ok, pop, full, push, drop;
  logic [IR_W-1:0] ir_lat;
  logic [AW:0] wptr, rptr;
  logic [IR_W+DATA_W-1:0] mem [DEPTH];
  dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_uir (.clk(clk), .reset_n(reset_n), .d(vs_uir), .rise(uir_rise));
  dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_udr (.clk(clk), .reset_n(reset_n), .d(vs_udr), .rise(udr_rise));
  assign cmd_valid = wptr != rptr;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign pop = cmd_valid & cmd_ready;
  assign push = udr_rise & par_ok & (~full | pop);
  assign drop = udr_rise & par_ok & full & ~pop;
  assign {cmd_ir, cmd_data} = mem[rptr[AW-1:0]];
  assign cmd_ch = cmd_valid ? NUM_CH'(1) << cmd_ir : '0;
  assign level = LW'(wptr - rptr);
  assign ir_update = uir_rise;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ir_lat <= '0;
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
    end else begin
      ir_lat <= uir_rise ? ir_in : ir_lat;
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(pop);
      overflow <= drop | (overflow & ~ovf_clr);
    end
  // ir_lat here is the pre-update value, so a same-cycle IR change applies to the next command
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= {ir_lat, sr};
`ifdef DBG_SLAVE_PARITY_EN
  assign par_ok = odd_parity_ok(64'(sr));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) perr_cnt <= '0;
    else perr_cnt <= (udr_rise & ~par_ok & (perr_cnt != 8'hff)) ? perr_cnt + 8'd1 : perr_cnt;
`else
  assign par_ok = 1'b1;
  assign perr_cnt = '0;
`endif
endmodule

// File: tb/tb_dbg_slave_cmd_queue.sv
// tb_dbg_slave_cmd_queue: directed scoreboard bench for dbg_slave_cmd_queue at default parameters
module tb_dbg_slave_cmd_queue;
  import dbg_slave_pkg::*;
  logic clk = 0, reset_n = 0, vs_uir = 0, vs_udr = 0, cmd_ready = 0, ovf_clr = 0;
  logic [1:0] ir_in = '0;
  logic [37:0] sr = '0;
  logic cmd_valid, ir_update, overflow;
  logic [37:0] cmd_data;
  logic [1:0] cmd_ir;
  logic [3:0] cmd_ch;
  logic [2:0] level;
  logic [7:0] perr_cnt;
  int n_chk = 0, n_fail = 0;
  cmd_t sb[$];
  dbg_slave_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_ir(cmd_ir),
    .cmd_ch(cmd_ch), .ir_update(ir_update), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .perr_cnt(perr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [37:0] fix(input logic [37:0] d);
`ifdef DBG_SLAVE_PARITY_EN
    return {~^d[36:0], d[36:0]};
`else
    return d;
`endif
  endfunction
  task automatic udr_pulse(input logic [37:0] d);
    @(negedge clk);
    sr = d;
    vs_udr = 1;
    repeat (6) @(posedge clk);
    #1 vs_udr = 0;
    repeat (6) @(posedge clk);
    #1;
  endtask
  task automatic pop_chk(input string tag);
    cmd_t e;
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    else begin
      e = sb.pop_front();
      chk(tag, 64'({cmd_ir, cmd_data}), 64'(e));
    end
    cmd_ready = 1;
    @(posedge clk);
    #1 cmd_ready = 0;
  endtask
  initial begin
    cmd_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ch", 64'(cmd_ch), 64'd0);
    chk("rst_irupd", 64'(ir_update), 64'd0);
    chk("rst_perr", 64'(perr_cnt), 64'd0);
    @(negedge clk) reset_n = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    ir_in = 2'b10;
    vs_uir = 1;
    repeat (3) @(posedge clk);
    #1 chk("irupd_e3", 64'(ir_update), 64'd0);
    @(posedge clk);
    #1 chk("irupd_e4", 64'(ir_update), 64'd1);
    @(posedge clk);
    #1 chk("irupd_e5", 64'(ir_update), 64'd0);
    vs_uir = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    sr = fix(38'h0_DEAD_BEEF);
    vs_udr = 1;
    e = {2'b10, sr};
    sb.push_back(e);
    repeat (4) @(posedge clk);
    #1 chk("valid_e4", 64'(cmd_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("valid_e5", 64'(cmd_valid), 64'd1);
    chk("head_ir", 64'(cmd_ir), 64'd2);
    chk("head_ch", 64'(cmd_ch), 64'h4);
    chk("head_data", 64'(cmd_data), 64'(fix(38'h0_DEAD_BEEF)));
    repeat (5) @(posedge clk);
    #1 vs_udr = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("hold_data", 64'(cmd_data), 64'(fix(38'h0_DEAD_BEEF)));
    chk("one_push_level", 64'(level), 64'd1);
    pop_chk("pop_first");
    chk("drained_valid", 64'(cmd_valid), 64'd0);
    chk("drained_level", 64'(level), 64'd0);
    for (int i = 0; i < 5; i++) begin
      udr_pulse(fix(38'h1_0000_0000 + 38'(i)));
      e = {2'b10, sr};
      if (i < 4) sb.push_back(e);
    end
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_set", 64'(overflow), 64'd1);
    @(negedge clk) ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    chk("ovf_clr", 64'(overflow), 64'd0);
    chk("ovf_clr_level", 64'(level), 64'd4);
    @(negedge clk);
    sr = fix(38'h2_0000_0005);
    vs_udr = 1;
    repeat (4) @(posedge clk);
    #1 pop_chk("coinc_pop");
    e = {2'b10, sr};
    sb.push_back(e);
    chk("coinc_level", 64'(level), 64'd4);
    chk("coinc_ovf", 64'(overflow), 64'd0);
    vs_udr = 0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pop_chk("order");
    chk("order_level", 64'(level), 64'd0);
    for (int i = 0; i < 3; i++) begin
      udr_pulse(fix(38'h3_0000_0000 + 38'(i)));
      e = {2'b10, sr};
      sb.push_back(e);
    end
    chk("pre_rst_level", 64'(level), 64'd3);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("async_valid", 64'(cmd_valid), 64'd0);
    chk("async_level", 64'(level), 64'd0);
    chk("async_ch", 64'(cmd_ch), 64'd0);
    sb.delete();
    vs_udr = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("held_level", 64'(level), 64'd0);
    chk("held_valid", 64'(cmd_valid), 64'd0);
    vs_udr = 0;
    repeat (6) @(posedge clk);
    udr_pulse(fix(38'h3_1234_5678));
    e = {2'b00, sr};
    sb.push_back(e);
    chk("post_rst_ch", 64'(cmd_ch), 64'h1);
    pop_chk("post_rst_pop");
`ifdef DBG_SLAVE_PARITY_EN
    udr_pulse(fix(38'h0_0000_00AA) ^ {1'b1, 37'd0});
    chk("perr_nopush", 64'(level), 64'd0);
    chk("perr_one", 64'(perr_cnt), 64'd1);
    for (int i = 0; i < 299; i++) udr_pulse(fix(38'(i)) ^ {1'b1, 37'd0});
    chk("perr_sat", 64'(perr_cnt), 64'd255);
    chk("perr_level", 64'(level), 64'd0);
`else
    chk("perr_tied", 64'(perr_cnt), 64'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
